// File: rtl/tsn_cmd_pkg.sv
// Shared types for the TSN command arbiter: FSM encoding, requester identity,
// default command width and the round-robin picker.
package tsn_cmd_pkg;

    localparam int unsigned CMD_W_DEF = 204;
    localparam int unsigned TO_W      = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StWaitAck = 2'd2
    } arb_state_e;

    typedef enum logic {
        ReqR0 = 1'b0,
        ReqR1 = 1'b1
    } req_id_e;

    // Only meaningful when at least one request is high.
    function automatic req_id_e rr_pick(input logic   req_r0,
                                        input logic   req_r1,
                                        input req_id_e ptr);
        if (req_r0 && req_r1) begin
            return ptr;
        end else if (req_r1) begin
            return ReqR1;
        end else begin
            return ReqR0;
        end
    endfunction

endpackage

// File: rtl/tsn_cmd_arbiter.sv
// Two-requester command arbiter: round-robin grant, write/read issue toward the
// datapath, and routing of the read ack back to its owner with a bounded wait.
module tsn_cmd_arbiter
    import tsn_cmd_pkg::*;
#(
    parameter int unsigned     CMD_W       = CMD_W_DEF,
    parameter logic [TO_W-1:0] ACK_TIMEOUT = 8'd255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,

    input  logic [CMD_W-1:0] iv_cmd_r0,
    input  logic [CMD_W-1:0] iv_cmd_r1,
    input  logic             i_cmd_rd_r0,
    input  logic             i_cmd_rd_r1,
    input  logic             i_cmd_req_r0,
    input  logic             i_cmd_req_r1,
    output logic             o_cmd_gnt_r0,
    output logic             o_cmd_gnt_r1,

    output logic [CMD_W-1:0] ov_wr_command,
    output logic             o_wr_command_wr,
    output logic [CMD_W-1:0] ov_rd_command,
    output logic             o_rd_command_wr,

    input  logic [CMD_W-1:0] iv_rd_command_ack,
    input  logic             i_rd_command_ack_wr,

    output logic [CMD_W-1:0] ov_rd_ack_r0,
    output logic [CMD_W-1:0] ov_rd_ack_r1,
    output logic             o_rd_ack_wr_r0,
    output logic             o_rd_ack_wr_r1,
    output logic             o_ack_timeout_pulse
);

    arb_state_e      state_q, state_d;
    req_id_e         ptr_q, ptr_d;
    req_id_e         owner_q, owner_d;
    logic            is_rd_q, is_rd_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic             gnt_r0_q, gnt_r0_d;
    logic             gnt_r1_q, gnt_r1_d;
    logic [CMD_W-1:0] wr_cmd_q, wr_cmd_d;
    logic             wr_cmd_wr_q, wr_cmd_wr_d;
    logic [CMD_W-1:0] rd_cmd_q, rd_cmd_d;
    logic             rd_cmd_wr_q, rd_cmd_wr_d;
    logic [CMD_W-1:0] rd_ack_r0_q, rd_ack_r0_d;
    logic [CMD_W-1:0] rd_ack_r1_q, rd_ack_r1_d;
    logic             rd_ack_wr_r0_q, rd_ack_wr_r0_d;
    logic             rd_ack_wr_r1_q, rd_ack_wr_r1_d;
    logic             timeout_q, timeout_d;

    req_id_e          winner;
    logic             win_rd;
    logic [CMD_W-1:0] win_cmd;

    always_comb begin
        winner  = rr_pick(i_cmd_req_r0, i_cmd_req_r1, ptr_q);
        win_rd  = (winner == ReqR1) ? i_cmd_rd_r1 : i_cmd_rd_r0;
        win_cmd = (winner == ReqR1) ? iv_cmd_r1 : iv_cmd_r0;
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        is_rd_d        = is_rd_q;
        cnt_d          = cnt_q;
        gnt_r0_d       = 1'b0;
        gnt_r1_d       = 1'b0;
        wr_cmd_d       = wr_cmd_q;
        wr_cmd_wr_d    = 1'b0;
        rd_cmd_d       = rd_cmd_q;
        rd_cmd_wr_d    = 1'b0;
        rd_ack_r0_d    = rd_ack_r0_q;
        rd_ack_r1_d    = rd_ack_r1_q;
        rd_ack_wr_r0_d = 1'b0;
        rd_ack_wr_r1_d = 1'b0;
        timeout_d      = 1'b0;

        case (state_q)
            StIdle: begin
                // Issue-cycle outputs are registered here so they line up with StIssue.
                if (i_cmd_req_r0 || i_cmd_req_r1) begin
                    state_d  = StIssue;
                    owner_d  = winner;
                    is_rd_d  = win_rd;
                    ptr_d    = (winner == ReqR0) ? ReqR1 : ReqR0;
                    gnt_r0_d = (winner == ReqR0);
                    gnt_r1_d = (winner == ReqR1);
                    if (win_rd) begin
                        rd_cmd_d    = win_cmd;
                        rd_cmd_wr_d = 1'b1;
                    end else begin
                        wr_cmd_d    = win_cmd;
                        wr_cmd_wr_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (is_rd_q) begin
                    state_d = StWaitAck;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StWaitAck: begin
                // An ack in the expiry cycle takes precedence over the timeout.
                if (i_rd_command_ack_wr) begin
                    state_d = StIdle;
                    if (owner_q == ReqR1) begin
                        rd_ack_r1_d    = iv_rd_command_ack;
                        rd_ack_wr_r1_d = 1'b1;
                    end else begin
                        rd_ack_r0_d    = iv_rd_command_ack;
                        rd_ack_wr_r0_d = 1'b1;
                    end
                end else if (cnt_q == ACK_TIMEOUT) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= StIdle;
            ptr_q          <= ReqR0;
            owner_q        <= ReqR0;
            is_rd_q        <= 1'b0;
            cnt_q          <= '0;
            gnt_r0_q       <= 1'b0;
            gnt_r1_q       <= 1'b0;
            wr_cmd_q       <= '0;
            wr_cmd_wr_q    <= 1'b0;
            rd_cmd_q       <= '0;
            rd_cmd_wr_q    <= 1'b0;
            rd_ack_r0_q    <= '0;
            rd_ack_r1_q    <= '0;
            rd_ack_wr_r0_q <= 1'b0;
            rd_ack_wr_r1_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            is_rd_q        <= is_rd_d;
            cnt_q          <= cnt_d;
            gnt_r0_q       <= gnt_r0_d;
            gnt_r1_q       <= gnt_r1_d;
            wr_cmd_q       <= wr_cmd_d;
            wr_cmd_wr_q    <= wr_cmd_wr_d;
            rd_cmd_q       <= rd_cmd_d;
            rd_cmd_wr_q    <= rd_cmd_wr_d;
            rd_ack_r0_q    <= rd_ack_r0_d;
            rd_ack_r1_q    <= rd_ack_r1_d;
            rd_ack_wr_r0_q <= rd_ack_wr_r0_d;
            rd_ack_wr_r1_q <= rd_ack_wr_r1_d;
            timeout_q      <= timeout_d;
        end
    end

    assign o_cmd_gnt_r0        = gnt_r0_q;
    assign o_cmd_gnt_r1        = gnt_r1_q;
    assign ov_wr_command       = wr_cmd_q;
    assign o_wr_command_wr     = wr_cmd_wr_q;
    assign ov_rd_command       = rd_cmd_q;
    assign o_rd_command_wr     = rd_cmd_wr_q;
    assign ov_rd_ack_r0        = rd_ack_r0_q;
    assign ov_rd_ack_r1        = rd_ack_r1_q;
    assign o_rd_ack_wr_r0      = rd_ack_wr_r0_q;
    assign o_rd_ack_wr_r1      = rd_ack_wr_r1_q;
    assign o_ack_timeout_pulse = timeout_q;

endmodule

// File: tb/tb_tsn_cmd_arbiter.sv
// Self-checking bench for tsn_cmd_arbiter: directed scenarios plus randomized
// transactions against a transaction-level reference model.
module tb_tsn_cmd_arbiter;

    localparam int unsigned W      = 204;
    localparam int          ACK_TO = 255;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] cmd_r0 = '0, cmd_r1 = '0, ack_data = '0;
    logic         rd_r0 = 1'b0, rd_r1 = 1'b0, req_r0 = 1'b0, req_r1 = 1'b0, ack_wr = 1'b0;
    logic         gnt_r0, gnt_r1, wr_cmd_wr, rd_cmd_wr, ack_wr_r0, ack_wr_r1, to_pulse;
    logic [W-1:0] wr_cmd, rd_cmd, ack_r0, ack_r1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: priority owner and last value seen on each held bus.
    int           exp_ptr;
    logic [W-1:0] m_wr_cmd, m_rd_cmd, m_ack0, m_ack1;

    logic [6:0]       pulses;
    logic [4*W+6:0]   all_out;
    assign pulses  = {gnt_r0, gnt_r1, wr_cmd_wr, rd_cmd_wr, ack_wr_r0, ack_wr_r1, to_pulse};
    assign all_out = {pulses, wr_cmd, rd_cmd, ack_r0, ack_r1};

    always #4 clk = ~clk;

    tsn_cmd_arbiter #(
        .CMD_W       (W),
        .ACK_TIMEOUT (8'd255)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .iv_cmd_r0           (cmd_r0),
        .iv_cmd_r1           (cmd_r1),
        .i_cmd_rd_r0         (rd_r0),
        .i_cmd_rd_r1         (rd_r1),
        .i_cmd_req_r0        (req_r0),
        .i_cmd_req_r1        (req_r1),
        .o_cmd_gnt_r0        (gnt_r0),
        .o_cmd_gnt_r1        (gnt_r1),
        .ov_wr_command       (wr_cmd),
        .o_wr_command_wr     (wr_cmd_wr),
        .ov_rd_command       (rd_cmd),
        .o_rd_command_wr     (rd_cmd_wr),
        .iv_rd_command_ack   (ack_data),
        .i_rd_command_ack_wr (ack_wr),
        .ov_rd_ack_r0        (ack_r0),
        .ov_rd_ack_r1        (ack_r1),
        .o_rd_ack_wr_r0      (ack_wr_r0),
        .o_rd_ack_wr_r1      (ack_wr_r1),
        .o_ack_timeout_pulse (to_pulse)
    );

    function automatic logic [W-1:0] rand_cmd();
        logic [223:0] v;
        for (int i = 0; i < 7; i++) v[i*32 +: 32] = $urandom;
        return v[W-1:0];
    endfunction

    // Round-robin rule: the pointer breaks ties, a lone requester always wins.
    function automatic int model_pick(input bit q0, input bit q1);
        if (q0 && q1) return exp_ptr;
        return q1 ? 1 : 0;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_ptr  = 0;
        m_wr_cmd = '0;
        m_rd_cmd = '0;
        m_ack0   = '0;
        m_ack1   = '0;
    endtask

    task automatic apply_reset();
        step();
        rst_n = 1'b0;
        req_r0 = 1'b0; req_r1 = 1'b0; ack_wr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [W-1:0] c;
        rst_n = 1'b0;
        cmd_r0 = rand_cmd(); cmd_r1 = rand_cmd(); ack_data = rand_cmd();
        step();
        step();
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pulses=%b wr=%h want all zero", pulses, wr_cmd);
        end
        // First edge with reset high must already sample.
        c = rand_cmd();
        cmd_r1 = c; rd_r1 = 1'b0; req_r1 = 1'b1;
        rst_n = 1'b1;
        model_reset();
        exp_ptr = 1 - model_pick(1'b0, 1'b1);
        m_wr_cmd = c;
        step();
        req_r1 = 1'b0;
        n_tests++;
        if (pulses !== 7'b0110000) begin
            n_fail++;
            $display("FAIL first_sample_grant: got %b want %b", pulses, 7'b0110000);
        end
        n_tests++;
        if (wr_cmd !== m_wr_cmd) begin
            n_fail++;
            $display("FAIL first_sample_cmd: got %h want %h", wr_cmd, m_wr_cmd);
        end
        step();
        n_tests++;
        if (pulses !== 7'b0) begin
            n_fail++;
            $display("FAIL first_sample_pulse_width: got %b want 0", pulses);
        end
    endtask

    task automatic test_write_r0();
        int w;
        cmd_r0 = 204'hA5; rd_r0 = 1'b0; req_r0 = 1'b1;
        cmd_r1 = rand_cmd(); req_r1 = 1'b0;
        w = model_pick(1'b1, 1'b0);
        exp_ptr = 1 - w;
        m_wr_cmd = cmd_r0;
        step();
        req_r0 = 1'b0;
        n_tests++;
        if (pulses !== 7'b1010000) begin
            n_fail++;
            $display("FAIL write_r0_grant: got %b want %b", pulses, 7'b1010000);
        end
        n_tests++;
        if (wr_cmd !== m_wr_cmd) begin
            n_fail++;
            $display("FAIL write_r0_cmd: got %h want %h", wr_cmd, m_wr_cmd);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (pulses !== 7'b0 || wr_cmd !== m_wr_cmd) begin
                n_fail++;
                $display("FAIL write_r0_quiet: got pulses=%b wr=%h want 0 and %h",
                         pulses, wr_cmd, m_wr_cmd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] c0, c1;
        logic [6:0]   exp_p;
        int           w;
        apply_reset();
        c0 = rand_cmd(); c1 = rand_cmd();
        cmd_r0 = c0; cmd_r1 = c1; rd_r0 = 1'b0; rd_r1 = 1'b0;
        req_r0 = 1'b1; req_r1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_p = 7'b0;
            if (i % 2 == 0) begin
                w = model_pick(1'b1, 1'b1);
                exp_ptr = 1 - w;
                m_wr_cmd = (w == 1) ? c1 : c0;
                exp_p = {(w == 0), (w == 1), 1'b1, 1'b0, 3'b000};
            end
            n_tests++;
            if (pulses !== exp_p || wr_cmd !== m_wr_cmd) begin
                n_fail++;
                $display("FAIL alternate_grant[%0d]: got %b/%h want %b/%h",
                         i, pulses, wr_cmd, exp_p, m_wr_cmd);
            end
        end
        req_r0 = 1'b0; req_r1 = 1'b0;
    endtask

    task automatic test_read_ack();
        int w;
        cmd_r1 = 204'h3C; rd_r1 = 1'b1; req_r1 = 1'b1; req_r0 = 1'b0;
        w = model_pick(1'b0, 1'b1);
        exp_ptr = 1 - w;
        m_rd_cmd = cmd_r1;
        step();
        req_r1 = 1'b0;
        n_tests++;
        if (pulses !== 7'b0101000 || rd_cmd !== m_rd_cmd || wr_cmd !== m_wr_cmd) begin
            n_fail++;
            $display("FAIL read_r1_issue: got %b/%h want %b/%h", pulses, rd_cmd, 7'b0101000,
                     m_rd_cmd);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            n_tests++;
            if (pulses !== 7'b0) begin
                n_fail++;
                $display("FAIL read_r1_wait[%0d]: got %b want 0", k, pulses);
            end
            if (k == 9) begin
                ack_data = 204'h77;
                ack_wr = 1'b1;
            end
        end
        step();
        ack_wr = 1'b0;
        m_ack1 = 204'h77;
        n_tests++;
        if (pulses !== 7'b0000010 || ack_r1 !== m_ack1) begin
            n_fail++;
            $display("FAIL read_r1_ack: got %b/%h want %b/%h", pulses, ack_r1, 7'b0000010, m_ack1);
        end
        n_tests++;
        if (ack_r0 !== m_ack0) begin
            n_fail++;
            $display("FAIL read_r1_r0_untouched: got %h want %h", ack_r0, m_ack0);
        end
        step();
        n_tests++;
        if (pulses !== 7'b0 || ack_r1 !== m_ack1) begin
            n_fail++;
            $display("FAIL read_r1_after: got %b/%h want 0/%h", pulses, ack_r1, m_ack1);
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] c2;
        int           w;
        cmd_r0 = rand_cmd(); rd_r0 = 1'b1; req_r0 = 1'b1; req_r1 = 1'b0;
        w = model_pick(1'b1, 1'b0);
        exp_ptr = 1 - w;
        m_rd_cmd = cmd_r0;
        step();
        req_r0 = 1'b0;
        n_tests++;
        if (pulses !== 7'b1001000 || rd_cmd !== m_rd_cmd) begin
            n_fail++;
            $display("FAIL timeout_issue: got %b/%h want %b/%h", pulses, rd_cmd, 7'b1001000,
                     m_rd_cmd);
        end
        c2 = rand_cmd();
        for (int k = 0; k <= ACK_TO; k++) begin
            step();
            n_tests++;
            if (pulses !== 7'b0) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d]: got %b want 0", k, pulses);
            end
            if (k == 3) begin
                cmd_r0 = c2; rd_r0 = 1'b0; req_r0 = 1'b1;
            end
        end
        step();
        n_tests++;
        if (pulses !== 7'b0000001 || ack_r0 !== m_ack0 || ack_r1 !== m_ack1) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %b want %b", pulses, 7'b0000001);
        end
        w = model_pick(1'b1, 1'b0);
        exp_ptr = 1 - w;
        m_wr_cmd = c2;
        step();
        req_r0 = 1'b0;
        n_tests++;
        if (pulses !== 7'b1010000 || wr_cmd !== m_wr_cmd) begin
            n_fail++;
            $display("FAIL timeout_pending_write: got %b/%h want %b/%h", pulses, wr_cmd,
                     7'b1010000, m_wr_cmd);
        end
        step();
    endtask

    task automatic test_ack_at_timeout();
        logic [W-1:0] ad;
        int           w;
        cmd_r1 = rand_cmd(); rd_r1 = 1'b1; req_r1 = 1'b1; req_r0 = 1'b0;
        w = model_pick(1'b0, 1'b1);
        exp_ptr = 1 - w;
        m_rd_cmd = cmd_r1;
        step();
        req_r1 = 1'b0;
        n_tests++;
        if (pulses !== 7'b0101000 || rd_cmd !== m_rd_cmd) begin
            n_fail++;
            $display("FAIL ack_at_to_issue: got %b/%h want %b/%h", pulses, rd_cmd, 7'b0101000,
                     m_rd_cmd);
        end
        ad = rand_cmd();
        for (int k = 0; k <= ACK_TO; k++) begin
            step();
            n_tests++;
            if (pulses !== 7'b0) begin
                n_fail++;
                $display("FAIL ack_at_to_wait[%0d]: got %b want 0", k, pulses);
            end
            if (k == ACK_TO) begin
                ack_data = ad;
                ack_wr = 1'b1;
            end
        end
        step();
        ack_wr = 1'b0;
        m_ack1 = ad;
        n_tests++;
        if (pulses !== 7'b0000010 || ack_r1 !== m_ack1) begin
            n_fail++;
            $display("FAIL ack_at_to_forward: got %b/%h want %b/%h", pulses, ack_r1, 7'b0000010,
                     m_ack1);
        end
        step();
        n_tests++;
        if (pulses !== 7'b0) begin
            n_fail++;
            $display("FAIL ack_at_to_no_late_pulse: got %b want 0", pulses);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [W-1:0] c0;
        int           w;
        cmd_r0 = rand_cmd(); rd_r0 = 1'b1; req_r0 = 1'b1; req_r1 = 1'b0;
        step();
        req_r0 = 1'b0;
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait_async: got pulses=%b want all zero", pulses);
        end
        step();
        step();
        ack_data = rand_cmd();
        ack_wr = 1'b1;
        rst_n = 1'b1;
        model_reset();
        step();
        ack_wr = 1'b0;
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_late_ack: got pulses=%b ack_r0=%h want all zero", pulses, ack_r0);
        end
        c0 = rand_cmd();
        cmd_r0 = c0; cmd_r1 = rand_cmd(); rd_r0 = 1'b0; rd_r1 = 1'b0;
        req_r0 = 1'b1; req_r1 = 1'b1;
        w = model_pick(1'b1, 1'b1);
        exp_ptr = 1 - w;
        m_wr_cmd = (w == 1) ? cmd_r1 : c0;
        step();
        req_r0 = 1'b0; req_r1 = 1'b0;
        n_tests++;
        if (pulses !== {(w == 0), (w == 1), 5'b10000} || wr_cmd !== m_wr_cmd) begin
            n_fail++;
            $display("FAIL reset_ptr_r0: got %b/%h want r0 grant/%h", pulses, wr_cmd, m_wr_cmd);
        end
        step();
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            logic [W-1:0] c0, c1, cw, ad;
            logic [1:0]   mask;
            logic [6:0]   exp_p;
            bit           rd0, rd1, rdw;
            int           w, mode, ack_k;

            if ($urandom_range(0, 3) == 0) begin
                ack_data = rand_cmd();
                ack_wr = 1'b1;
                step();
                ack_wr = 1'b0;
                n_tests++;
                if (pulses !== 7'b0 || ack_r0 !== m_ack0 || ack_r1 !== m_ack1) begin
                    n_fail++;
                    $display("FAIL rand_idle_ack[%0d]: got %b/%h/%h want 0/%h/%h",
                             it, pulses, ack_r0, ack_r1, m_ack0, m_ack1);
                end
            end

            mask = 2'($urandom_range(1, 3));
            rd0 = 1'($urandom_range(0, 1));
            rd1 = 1'($urandom_range(0, 1));
            c0 = rand_cmd(); c1 = rand_cmd();
            cmd_r0 = c0; cmd_r1 = c1; rd_r0 = rd0; rd_r1 = rd1;
            req_r0 = mask[0]; req_r1 = mask[1];
            w = model_pick(mask[0], mask[1]);
            exp_ptr = 1 - w;
            rdw = (w == 1) ? rd1 : rd0;
            cw = (w == 1) ? c1 : c0;
            if (rdw) m_rd_cmd = cw;
            else m_wr_cmd = cw;
            exp_p = {(w == 0), (w == 1), !rdw, rdw, 3'b000};
            step();
            req_r0 = 1'b0; req_r1 = 1'b0;
            n_tests++;
            if (pulses !== exp_p || wr_cmd !== m_wr_cmd || rd_cmd !== m_rd_cmd) begin
                n_fail++;
                $display("FAIL rand_issue[%0d]: got %b wr=%h rd=%h want %b wr=%h rd=%h",
                         it, pulses, wr_cmd, rd_cmd, exp_p, m_wr_cmd, m_rd_cmd);
            end

            if (!rdw) begin
                step();
                n_tests++;
                if (pulses !== 7'b0) begin
                    n_fail++;
                    $display("FAIL rand_write_end[%0d]: got %b want 0", it, pulses);
                end
            end else begin
                mode = $urandom_range(0, 9);
                ack_k = (mode == 0) ? ACK_TO + 1 : (mode == 1) ? ACK_TO : $urandom_range(0, 20);
                ad = rand_cmd();
                for (int k = 0; k <= ACK_TO; k++) begin
                    step();
                    req_r0 = 1'b0; req_r1 = 1'b0;
                    n_tests++;
                    if (pulses !== 7'b0) begin
                        n_fail++;
                        $display("FAIL rand_wait[%0d.%0d]: got %b want 0", it, k, pulses);
                    end
                    if (k == ack_k) begin
                        ack_data = ad;
                        ack_wr = 1'b1;
                        break;
                    end
                    // Short request pulse while busy must never be granted.
                    if (k == 1 && ack_k >= 3) begin
                        if ($urandom_range(0, 1) == 1) req_r1 = 1'b1;
                        else req_r0 = 1'b1;
                    end
                end
                step();
                ack_wr = 1'b0;
                if (ack_k <= ACK_TO) begin
                    if (w == 1) m_ack1 = ad;
                    else m_ack0 = ad;
                    exp_p = {4'b0000, (w == 0), (w == 1), 1'b0};
                end else begin
                    exp_p = 7'b0000001;
                end
                n_tests++;
                if (pulses !== exp_p || ack_r0 !== m_ack0 || ack_r1 !== m_ack1) begin
                    n_fail++;
                    $display("FAIL rand_read_end[%0d]: got %b/%h/%h want %b/%h/%h",
                             it, pulses, ack_r0, ack_r1, exp_p, m_ack0, m_ack1);
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_write_r0();
        test_back_to_back();
        test_read_ack();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tsn_cmd_arbiter.md
TSN_CMD_ARBITER -- requirements
Module: tsn_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter CMD_W, default 204, giving the command word width in bits.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 255, giving the maximum cycles to wait for a read ack; it is 8 bits wide.
REQ-003 Port i_clk, input, 1 bit: the single 125 MHz clock.
REQ-004 Port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Ports iv_cmd_r0 and iv_cmd_r1, input, CMD_W bits each: command word from requester 0 (hcp) and requester 1 (local).
REQ-006 Ports i_cmd_rd_r0 and i_cmd_rd_r1, input, 1 bit each: command type, 0 = write, 1 = read.
REQ-007 Ports i_cmd_req_r0 and i_cmd_req_r1, input, 1 bit each: level request, held until granted.
REQ-008 Ports o_cmd_gnt_r0 and o_cmd_gnt_r1, output, 1 bit each: one-cycle grant pulse.
REQ-009 Ports ov_wr_command (output, CMD_W bits) and o_wr_command_wr (output, 1 bit): write command bus toward the datapath.
REQ-010 Ports ov_rd_command (output, CMD_W bits) and o_rd_command_wr (output, 1 bit): read command bus toward the datapath.
REQ-011 Ports iv_rd_command_ack (input, CMD_W bits) and i_rd_command_ack_wr (input, 1 bit): read response from the datapath.
REQ-012 Ports ov_rd_ack_r0 and ov_rd_ack_r1 (output, CMD_W bits each), with o_rd_ack_wr_r0 and o_rd_ack_wr_r1 (output, 1 bit each): read response routed to the owning requester.
REQ-013 Port o_ack_timeout_pulse, output, 1 bit: one-cycle pulse when a read ack times out.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, ISSUE and WAIT_ACK.
REQ-015 In IDLE, at each clock edge, the FSM SHALL sample the requests and move to ISSUE if any request is high; otherwise it stays in IDLE.
REQ-016 Round-robin arbitration: when both requests are high, the requester selected by the priority pointer wins, and the pointer then moves to the other requester.
REQ-017 When only one request is high, that requester wins and the pointer moves away from the winner.
REQ-018 On the IDLE-to-ISSUE edge, the block SHALL latch the winner's command, type and identity.
REQ-019 For the one ISSUE cycle:
- the winner's o_cmd_gnt pulses high;
- for a write: ov_wr_command carries the command and o_wr_command_wr = 1;
- for a read: ov_rd_command carries the command and o_rd_command_wr = 1.
REQ-020 Latency from request sampled to grant and strobe SHALL be exactly 1 cycle; a write SHALL occupy 2 cycles before the next sample (ISSUE -> IDLE).
REQ-021 After ISSUE, a write SHALL return to IDLE and a read SHALL go to WAIT_ACK with the timeout counter cleared.
REQ-022 Requesters SHALL drop their request in the cycle after the grant; because IDLE samples one cycle after ISSUE, the same request is never granted twice.
REQ-023 In WAIT_ACK, i_rd_command_ack_wr SHALL cause:
- iv_rd_command_ack registered onto the owner's ov_rd_ack;
- owner's o_rd_ack_wr pulsed 1 cycle later;
- transition to IDLE.
REQ-024 In WAIT_ACK without an ack, the timeout counter SHALL increment each cycle; when it equals ACK_TIMEOUT, o_ack_timeout_pulse pulses, nothing is forwarded, and the FSM returns to IDLE.
REQ-025 If an ack and the timeout occur in the same cycle, the ack SHALL win and no timeout pulse is produced.
REQ-026 An ack outside WAIT_ACK SHALL be ignored and dropped.
REQ-027 ov_wr_command and ov_rd_command SHALL hold their last value when their strobe is low.
REQ-028 Request inputs SHALL be ignored in ISSUE and WAIT_ACK; a request that deasserts before being sampled is never granted.

Reset
REQ-029 Asserting i_rst_n low, at any time including mid-WAIT_ACK, SHALL asynchronously:
- force the FSM to IDLE;
- set the priority pointer to r0;
- clear the counter and latches;
- drive every output to 0.
REQ-030 After reset, a pending ack SHALL NOT be forwarded.
REQ-031 After reset release, the first sample SHALL occur on the first clock edge with i_rst_n high.

Structure
REQ-032 The FSM state encoding and the CMD_W default SHALL reside in the shared package tsn_cmd_pkg.
REQ-033 The block SHALL be a single module with no sub-modules, optionally with a round-robin picker function.

Verification
REQ-034 Write from r0 only, cmd=204'hA5: gnt_r0 and o_wr_command_wr pulse together 1 cycle after the sample; ov_wr_command=204'hA5; r1 never granted.
REQ-035 Both requesting writes continuously after reset: grants alternate r0, r1, r0, r1, spaced 2 cycles apart.
REQ-036 r1 reads cmd=204'h3C and the ack arrives 10 cycles later with value 204'h77: ov_rd_ack_r1=204'h77 and o_rd_ack_wr_r1 pulses 1 cycle after the ack; the r0 ack outputs stay 0.
REQ-037 Read with no ack: o_ack_timeout_pulse pulses at count 255 and the FSM is back in IDLE; a pending r0 write is then granted.
REQ-038 The ack arrives in the same cycle the counter hits 255: the ack is forwarded and there is no timeout pulse.
REQ-039 Reset asserted during WAIT_ACK, then a late ack: all outputs are 0 and the ack is not forwarded.
